// File: rtl/fifo_loopback_responder.sv
// Responder that stands in for the DDR3 write-FIFO / memory / read-FIFO path.
// Stores the generator's write stream in a circular buffer and releases it in latency-modelled fetch bursts.
module fifo_loopback_responder #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 11,
    parameter int BURST_LEN    = 8,
    parameter int FETCH_LAT    = 4,
    parameter int CALIB_CYCLES = 100
) (
    input  logic              clk,
    input  logic              rst,
    output logic              calib_done,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    input  logic              rd_mem_enable,
    output logic              rd_valid,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CNT_W   = ADDR_W + 1;
    localparam int LAT_W   = $clog2(FETCH_LAT + 1);
    localparam int CAL_W   = $clog2(CALIB_CYCLES + 1);
    localparam int BURST_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY
    } state_t;

    state_t             state_q;
    logic [CAL_W-1:0]   calCnt_q;
    logic               calibDone_q;
    logic [ADDR_W-1:0]  wrPtr_q;
    logic [ADDR_W-1:0]  fetchPtr_q;
    logic [ADDR_W-1:0]  rdPtr_q;
    logic [CNT_W-1:0]   stored_q;
    logic [CNT_W-1:0]   unfetched_q;
    logic [CNT_W-1:0]   avail_q;
    logic [BURST_W-1:0] burstN_q;
    logic [LAT_W-1:0]   latCnt_q;
    logic [DATA_W-1:0]  rdData_q;
    logic               overflow_q;
    logic               underflow_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               isFull;
    logic               wrAccept;
    logic               wrDrop;
    logic               rdAccept;
    logic               rdStray;
    logic               releaseNow;
    logic               startFetch;
    logic [CNT_W-1:0]   burstSize;
    logic [CNT_W-1:0]   releaseN;
    logic [CNT_W-1:0]   stored_d;
    logic [CNT_W-1:0]   unfetched_d;
    logic [CNT_W-1:0]   avail_d;

    // The full check uses the pre-update count, so a same-cycle read never rescues a write while full.
    always_comb begin
        isFull      = (stored_q == CNT_W'(DEPTH));
        wrAccept    = wr_en && calibDone_q && !isFull;
        wrDrop      = wr_en && calibDone_q && isFull;
        rdAccept    = rd_en && (avail_q != '0);
        rdStray     = rd_en && (avail_q == '0);
        releaseNow  = (state_q == FETCH) && (latCnt_q == '0);
        startFetch  = (state_q == IDLE) && rd_mem_enable && (unfetched_q != '0);
        burstSize   = (unfetched_q < CNT_W'(BURST_LEN)) ? unfetched_q : CNT_W'(BURST_LEN);
        releaseN    = releaseNow ? CNT_W'(burstN_q) : '0;
        stored_d    = stored_q + CNT_W'(wrAccept) - CNT_W'(rdAccept);
        unfetched_d = unfetched_q + CNT_W'(wrAccept) - releaseN;
        avail_d     = avail_q + releaseN - CNT_W'(rdAccept);
    end

    // Buffer storage carries no reset; a reset only discards the pointers into it.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            calCnt_q    <= '0;
            calibDone_q <= 1'b0;
            wrPtr_q     <= '0;
            fetchPtr_q  <= '0;
            rdPtr_q     <= '0;
            stored_q    <= '0;
            unfetched_q <= '0;
            avail_q     <= '0;
            burstN_q    <= '0;
            latCnt_q    <= '0;
            rdData_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (!calibDone_q) begin
                if (calCnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                    calibDone_q <= 1'b1;
                end else begin
                    calCnt_q <= calCnt_q + CAL_W'(1);
                end
            end

            stored_q    <= stored_d;
            unfetched_q <= unfetched_d;
            avail_q     <= avail_d;

            if (wrAccept) begin
                wrPtr_q <= wrPtr_q + ADDR_W'(1);
            end
            if (wrDrop) begin
                overflow_q <= 1'b1;
            end
            if (rdAccept) begin
                rdData_q <= mem[rdPtr_q];
                rdPtr_q  <= rdPtr_q + ADDR_W'(1);
            end
            if (rdStray) begin
                underflow_q <= 1'b1;
            end

            // Burst size is frozen on entry; later writes wait for the next fetch.
            case (state_q)
                IDLE: begin
                    if (startFetch) begin
                        state_q  <= FETCH;
                        burstN_q <= BURST_W'(burstSize);
                        latCnt_q <= LAT_W'(FETCH_LAT - 1);
                    end
                end
                FETCH: begin
                    if (releaseNow) begin
                        state_q    <= READY;
                        fetchPtr_q <= fetchPtr_q + ADDR_W'(burstN_q);
                    end else begin
                        latCnt_q <= latCnt_q - LAT_W'(1);
                    end
                end
                READY: begin
                    if (avail_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rd_valid drops one word early so a generator registering rd_en never over-reads.
    assign rd_valid   = (state_q == READY) && (avail_q > CNT_W'(rd_en));
    assign wr_full    = isFull;
    assign calib_done = calibDone_q;
    assign rd_data    = rdData_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: doc/fifo_loopback_responder.md
Name: fifo_loopback_responder

Overview:
- Synthesisable stand-in for the DDR3 write-FIFO / memory / read-FIFO path, used in simulation and board bring-up of the test-data generator/checker.
- Provides the responder side of that interface:
  - raises calib_done after a fixed delay;
  - accepts the write stream into an internal circular buffer;
  - once reads are enabled, releases stored words in fetch bursts with modelled latency;
  - returns each word one cycle after rd_en.
- Sits in the top-level test harness in place of the memory controller plus FIFOs.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 11, buffer address width; depth = 2**ADDR_W words (2048)
- BURST_LEN, 8, maximum words released per fetch
- FETCH_LAT, 4, cycles spent in FETCH before words are released (≥1)
- CALIB_CYCLES, 100, cycles after reset release before calib_done rises (≥1)

Ports:
- clk  input  1  single clock, shared with the generator
- rst  input  1  synchronous, active-high reset
- calib_done  output  1  initialisation-complete flag
- wr_en  input  1  write strobe from the generator
- wr_data  input  DATA_W  write word
- wr_full  output  1  buffer full; writes are dropped while high
- rd_mem_enable  input  1  read permission; fetches start only while high
- rd_valid  output  1  at least one released word is available for a new rd_en
- rd_en  input  1  read strobe
- rd_data  output  DATA_W  read word, registered
- overflow  output  1  sticky: a write was dropped
- underflow  output  1  sticky: rd_en arrived with no released word

Behaviour:
- Reset:
  - Synchronous; every register clears on the rising clk edge with rst=1.
  - Values: calib_done=0, rd_data=0, overflow=0, underflow=0, state=IDLE.
  - All pointers and counters are 0.
  - rd_valid=0 and wr_full=0 follow from the cleared state.
  - rst mid-operation discards all buffered data; buffer memory contents need not clear.
- Calibration:
  - A counter increments each cycle after reset.
  - calib_done goes high in the cycle after the counter reaches CALIB_CYCLES-1, i.e. CALIB_CYCLES cycles after rst deasserts.
  - calib_done then holds high until the next reset.
- Pointers and counts:
  - wr_ptr, fetch_ptr and rd_ptr are ADDR_W bits and wrap modulo depth.
  - stored = occupied words, ADDR_W+1 bits.
  - unfetched = stored words not yet released.
  - avail = released words not yet read.
  - Invariant: unfetched + avail == stored.
- Write side:
  - A write is accepted when wr_en=1, calib_done=1 and stored<depth.
  - On acceptance: mem[wr_ptr]<=wr_data, wr_ptr++, unfetched++.
  - wr_en while full sets overflow and changes nothing else.
  - wr_en before calib_done is silently ignored; overflow is not set.
  - wr_full = (stored==depth), combinational.
- Fetch FSM:
  - IDLE → FETCH when rd_mem_enable=1 and unfetched>0. On entry, latch n = min(BURST_LEN, unfetched) and load the latency counter.
  - FETCH: counts FETCH_LAT cycles. On the last cycle: avail+=n, unfetched-=n, fetch_ptr+=n, then → READY.
  - READY → IDLE on the cycle avail reaches 0.
  - rd_mem_enable dropping during FETCH does not abort the fetch.
  - Writes arriving during FETCH/READY are counted in unfetched but do not join the current burst.
- Read side:
  - rd_valid = (state==READY) && (avail > rd_en), combinational.
  - This ensures a generator that registers rd_en from rd_valid never over-reads the last word.
  - rd_en with avail>0: rd_data<=mem[rd_ptr] on that edge (visible the cycle after rd_en), then rd_ptr++, avail--, stored--.
  - rd_en with avail==0: sets underflow; rd_data holds; counters unchanged.
- Simultaneous accepted write and read in one cycle:
  - stored is net unchanged.
  - The full check uses the pre-update stored value, so a write while full is dropped even if a read occurs in the same cycle.
- Simultaneous release and read:
  - The final FETCH cycle and an rd_en in the same cycle cannot collide, because rd_en is only legal in READY.
  - A stray rd_en during FETCH is treated as underflow.
- Widths:
  - All arithmetic is unsigned.
  - Counters never wrap; the invariant bounds them by depth.

Test Plan:
- Calibration: deassert rst, drive nothing → calib_done=0 for 99 cycles, rises at cycle 100, stays high for 200 cycles.
- Generator flow: write 1300 words 0..1299 after calib_done, then hold rd_mem_enable=1 and set rd_en = registered rd_valid → data returns in order; the k-th word (k from 0) equals k one cycle after its rd_en; underflow=0; rd_valid never high in IDLE/FETCH; each burst of 8 is separated by ≥FETCH_LAT cycles.
- Tail burst: write 13 words, enable reads → bursts of 8 then 5; after 13 reads rd_valid=0 and state returns to IDLE.
- Full/overflow: write 2050 words without reading → wr_full high after 2048 writes, overflow=1, words 2048/2049 lost; reading returns 0..2047, and address wrap-around is verified by a further 10 writes/reads.
- Underflow and concurrent access: rd_en pulsed in IDLE → underflow=1, rd_data unchanged; with reads active, continuous writes give the correct stored count and data order.
- Reset mid-operation: assert rst during FETCH with 500 words stored → all outputs reset; calib_done re-delays 100 cycles; the next read returns the first word written after reset.
